// File: rtl/result_pkg.sv
// Shared types and width helpers for the multi-channel result collector.
// Wire order: payload bit 0 leaves first, then payload MSB, then the channel tag.
package result_pkg;

    localparam int DROP_W     = 16;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_REC_W  = 36;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int out_width(input int rec_w, input int num_ch);
        return rec_w + ch_width(num_ch);
    endfunction

    // Tag sits above the payload so an LSB-first shift emits payload before tag.
    typedef struct packed {
        logic [ch_width(DEF_NUM_CH)-1:0] ch;
        logic [DEF_REC_W-1:0]            payload;
    } rec_t;

endpackage

// File: rtl/result_collector_if.sv
// Record inputs, host pop/shift interface and status outputs of the collector.
interface result_collector_if #(
    parameter int NUM_CH = 4,
    parameter int REC_W  = 36,
    parameter int DEPTH  = 512
);
    import result_pkg::*;

    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0][REC_W-1:0] in_data;
    logic                         rd_req;
    logic                         out_bit;
    logic                         out_empty;
    logic [$clog2(DEPTH):0]       level;
    logic [DROP_W-1:0]            drop_count;

    modport master (
        output in_valid, in_data, rd_req,
        input  out_bit, out_empty, level, drop_count
    );

    modport slave (
        input  in_valid, in_data, rd_req,
        output out_bit, out_empty, level, drop_count
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the priority pointer,
// which then moves to the channel after the winner.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic [PW-1:0] ptr_q
);

    logic [PW-1:0] ptr_d;
    logic [PW-1:0] sel;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            sel = PW'(idx);
            if (en && !found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
                ptr_d    = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/result_collector.sv
// Gathers tagged records from NUM_CH lanes through per-channel hold registers
// into one FIFO, drained LSB-first through a one-bit shift register.
module result_collector
    import result_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int REC_W  = 36,
    parameter int DEPTH  = 512
) (
    input logic               clk,
    input logic               rst,
    result_collector_if.slave bus
);

    localparam int CH_W   = ch_width(NUM_CH);
    localparam int OUT_W  = out_width(REC_W, NUM_CH);
    localparam int AW     = $clog2(DEPTH);
    localparam int LVL_W  = AW + 1;
    localparam int DSUM_W = DROP_W + 1;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [REC_W-1:0] payload;
    } rec_w_t;

    rec_w_t [NUM_CH-1:0] hold_q, hold_d;
    logic   [NUM_CH-1:0] hold_vld_q, hold_vld_d;
    logic   [NUM_CH-1:0] gnt, drop_vec;
    logic   [CH_W-1:0]   gnt_idx, unused_arb_ptr;
    logic   [DROP_W-1:0] drop_q, drop_d;
    logic   [DSUM_W-1:0] drop_sum;
    logic   [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic   [LVL_W-1:0]  level_q, level_d;
    logic                empty_q, empty_d, load_q, load_d;
    logic   [OUT_W-1:0]  shift_q, shift_d;
    logic                full, wr_en, pop;
    rec_w_t              rd_data_q;
    rec_w_t              mem [DEPTH];

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (!full),
        .req     (hold_vld_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .ptr_q   (unused_arb_ptr)
    );

    // A granted hold register is free again this cycle, so it can reload instead of dropping.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_hold
        always_comb begin
            hold_vld_d[c] = hold_vld_q[c];
            hold_d[c]     = hold_q[c];
            drop_vec[c]   = 1'b0;
            if (bus.in_valid[c]) begin
                if (!hold_vld_q[c] || gnt[c]) begin
                    hold_vld_d[c]     = 1'b1;
                    hold_d[c].ch      = CH_W'(c);
                    hold_d[c].payload = bus.in_data[c];
                end else begin
                    drop_vec[c] = 1'b1;
                end
            end else if (gnt[c]) begin
                hold_vld_d[c] = 1'b0;
            end
        end
    end

    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        wr_en    = |gnt;
        pop      = bus.rd_req && !empty_q;
        drop_sum = {1'b0, drop_q} + DSUM_W'($countones(drop_vec));
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop);
        empty_d  = (level_d == '0);
        load_d   = pop;
        shift_d  = load_q ? rd_data_q : (shift_q >> 1);
    end

    // Unreset array with a registered read so the FIFO maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= hold_q[gnt_idx];
        if (pop)   rd_data_q     <= mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            hold_vld_q <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            load_q     <= 1'b0;
            shift_q    <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
        end
    end

    assign bus.out_bit    = shift_q[0];
    assign bus.out_empty  = empty_q;
    assign bus.level      = level_q;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: expected words queue up as records are
// driven and are compared bit-serially as the host drains them.
module tb_result_collector;
    import result_pkg::*;

    localparam int NUM_CH = 4;
    localparam int REC_W  = 36;
    localparam int DEPTH  = 4;
    localparam int OUT_W  = 38;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_collector_if #(.NUM_CH(NUM_CH), .REC_W(REC_W), .DEPTH(DEPTH)) bus ();

    result_collector #(.NUM_CH(NUM_CH), .REC_W(REC_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    rec_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = '0;
        bus.rd_req   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick(2);
        rst = 1'b0;
        sb.delete();
    endtask

    function automatic logic [35:0] dat(input int ch, input int cyc);
        return {4'h5, 12'(cyc), 4'(ch), 16'hA5C3};
    endfunction

    function automatic rec_t mk(input int ch, input logic [35:0] d);
        rec_t r;
        r.ch      = 2'(ch);
        r.payload = d;
        return r;
    endfunction

    task automatic drive_all(input int cyc);
        bus.in_valid = 4'hF;
        bus.in_data  = {dat(3, cyc), dat(2, cyc), dat(1, cyc), dat(0, cyc)};
    endtask

    // Call at the negedge of the cycle after rd_req; bit k appears k+1 cycles later.
    task automatic collect(input string tag);
        rec_t             exp;
        logic [OUT_W-1:0] w;
        check({tag, "_sb_has_word"}, 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            w   = '0;
            for (int k = 0; k < OUT_W; k++) begin
                tick(1);
                w[k] = bus.out_bit;
            end
            check(tag, 64'(w), 64'(exp));
        end
        tick(1);
    endtask

    task automatic read_word(input string tag);
        bus.rd_req = 1'b1;
        tick(1);
        bus.rd_req = 1'b0;
        collect(tag);
    endtask

    initial begin
        idle();
        bus.in_data = '0;
        tick(3);
        rst = 1'b0;
        check("rst_out_bit", 64'(bus.out_bit), 64'(0));
        check("rst_empty", 64'(bus.out_empty), 64'(1));
        check("rst_level", 64'(bus.level), 64'(0));
        check("rst_drop", 64'(bus.drop_count), 64'(0));

        // Single record on channel 2, then drain it.
        bus.in_valid = 4'b0100;
        bus.in_data  = '0;
        bus.in_data[2] = 36'h123456789;
        sb.push_back(mk(2, 36'h123456789));
        tick(1);
        idle();
        check("t1_level_t1", 64'(bus.level), 64'(0));
        tick(1);
        check("t1_level_t2", 64'(bus.level), 64'(1));
        check("t1_empty_t2", 64'(bus.out_empty), 64'(0));
        bus.rd_req = 1'b1;
        tick(1);
        bus.rd_req = 1'b0;
        check("t1_level_pop", 64'(bus.level), 64'(0));
        collect("t1_word");
        check("t1_empty_end", 64'(bus.out_empty), 64'(1));

        // Four channels at once land in channel order.
        do_reset();
        drive_all(0);
        sb.push_back(mk(0, dat(0, 0)));
        sb.push_back(mk(1, dat(1, 0)));
        sb.push_back(mk(2, dat(2, 0)));
        sb.push_back(mk(3, dat(3, 0)));
        tick(1);
        idle();
        tick(3);
        check("t2_level_t4", 64'(bus.level), 64'(3));
        tick(1);
        check("t2_level_t5", 64'(bus.level), 64'(4));
        read_word("t2_ch0");
        read_word("t2_ch1");
        read_word("t2_ch2");
        read_word("t2_ch3");

        // Three busy cycles on all channels: grants rotate, six records dropped.
        do_reset();
        for (int cyc = 0; cyc < 3; cyc++) begin
            drive_all(cyc);
            tick(1);
        end
        idle();
        sb.push_back(mk(0, dat(0, 0)));
        sb.push_back(mk(1, dat(1, 0)));
        sb.push_back(mk(2, dat(2, 0)));
        sb.push_back(mk(3, dat(3, 0)));
        sb.push_back(mk(0, dat(0, 1)));
        sb.push_back(mk(1, dat(1, 2)));
        tick(4);
        check("t3_level_full", 64'(bus.level), 64'(4));
        check("t3_drop", 64'(bus.drop_count), 64'(6));
        for (int i = 0; i < 6; i++) read_word($sformatf("t3_word%0d", i));
        check("t3_level_end", 64'(bus.level), 64'(0));
        check("t3_drop_end", 64'(bus.drop_count), 64'(6));

        // Full FIFO: fifth record waits in its hold register, a sixth drops.
        do_reset();
        drive_all(10);
        sb.push_back(mk(0, dat(0, 10)));
        sb.push_back(mk(1, dat(1, 10)));
        sb.push_back(mk(2, dat(2, 10)));
        sb.push_back(mk(3, dat(3, 10)));
        tick(1);
        idle();
        tick(5);
        check("t4_level_full", 64'(bus.level), 64'(4));
        bus.in_valid = 4'b0001;
        bus.in_data[0] = dat(0, 11);
        sb.push_back(mk(0, dat(0, 11)));
        tick(1);
        idle();
        tick(2);
        check("t4_level_held", 64'(bus.level), 64'(4));
        check("t4_drop_none", 64'(bus.drop_count), 64'(0));
        bus.in_valid = 4'b0001;
        bus.in_data[0] = dat(0, 12);
        tick(1);
        idle();
        tick(1);
        check("t4_drop_one", 64'(bus.drop_count), 64'(1));
        bus.rd_req = 1'b1;
        tick(1);
        bus.rd_req = 1'b0;
        check("t4_level_pop", 64'(bus.level), 64'(3));
        collect("t4_word0");
        check("t4_level_refill", 64'(bus.level), 64'(4));
        for (int i = 1; i < 5; i++) read_word($sformatf("t4_word%0d", i));
        check("t4_drop_end", 64'(bus.drop_count), 64'(1));

        // Pop on empty is ignored; then saturate the drop counter.
        do_reset();
        bus.rd_req = 1'b1;
        tick(1);
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("t5_empty_bit%0d", i), 64'(bus.out_bit), 64'(0));
        end
        check("t5_empty_level", 64'(bus.level), 64'(0));
        check("t5_empty_flag", 64'(bus.out_empty), 64'(1));
        drive_all(30);
        tick(1);
        idle();
        tick(6);
        drive_all(31);
        tick(101);
        check("t5_drop_400", 64'(bus.drop_count), 64'(400));
        tick(16500);
        check("t5_drop_sat", 64'(bus.drop_count), 64'(16'hFFFF));
        idle();
        tick(3);
        check("t5_drop_hold", 64'(bus.drop_count), 64'(16'hFFFF));

        // Reset while bit 10 of a word is on the wire.
        do_reset();
        bus.in_valid = 4'b0011;
        bus.in_data  = '0;
        bus.in_data[0] = 36'hFFFFFFFFF;
        bus.in_data[1] = dat(1, 20);
        sb.push_back(mk(0, 36'hFFFFFFFFF));
        sb.push_back(mk(1, dat(1, 20)));
        tick(1);
        bus.in_data[0] = dat(0, 21);
        bus.in_data[1] = dat(1, 21);
        sb.push_back(mk(0, dat(0, 21)));
        tick(1);
        idle();
        tick(4);
        check("t6_drop", 64'(bus.drop_count), 64'(1));
        check("t6_level", 64'(bus.level), 64'(3));
        bus.rd_req = 1'b1;
        tick(1);
        bus.rd_req = 1'b0;
        tick(11);
        check("t6_bit10", 64'(bus.out_bit), 64'(1));
        rst = 1'b1;
        tick(1);
        check("t6_rst_bit", 64'(bus.out_bit), 64'(0));
        check("t6_rst_empty", 64'(bus.out_empty), 64'(1));
        check("t6_rst_level", 64'(bus.level), 64'(0));
        check("t6_rst_drop", 64'(bus.drop_count), 64'(0));
        rst = 1'b0;
        sb.delete();
        tick(3);
        check("t6_post_bit", 64'(bus.out_bit), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
